alu_seq: RTL

- Parametrised, registered successor to the combinational data-processing ALU.
- Executes all 16 ARM data-processing opcodes with correct NZCV semantics, including C/V hold and an S (set-flags) control.
- Adds a multi-cycle iterative multiply / multiply-accumulate (MUL/MLA).
- Sits between the register-read stage and write-back; accepts one operation per valid/ready handshake and returns a registered result plus a flag register.

---
 rtl/alu_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered ARM data-processing ALU with NZCV flag register and valid/ready handshake.
// Optional iterative MUL/MLA path is built only when the ALU_MUL_EN macro is defined.
module alu_seq #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic             set_flags,
  input  logic             mul_en,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  input  logic             shift_carry,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             write_rd,
  output logic [3:0]       flags
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             out_valid_q;
  logic             write_rd_q;

  logic             accept;
  logic             mulReq;
  logic [WIDTH-1:0] x, y, logicRes, aluRes;
  logic [WIDTH:0]   sum;
  logic             cin, isArith, isCompare, updFlags;
  logic             aluN, aluZ, aluC, aluV;

  assign accept = in_valid && in_ready;

  // Operand selection: arithmetic ops feed a single WIDTH+1 adder, the rest are bitwise.
  always_comb begin
    x        = '0;
    y        = '0;
    cin      = 1'b0;
    isArith  = 1'b1;
    logicRes = '0;
    case (opcode)
      4'h2, 4'hA: begin x = a; y = ~b; cin = 1'b1;       end
      4'h3:       begin x = b; y = ~a; cin = 1'b1;       end
      4'h4, 4'hB: begin x = a; y = b;  cin = 1'b0;       end
      4'h5:       begin x = a; y = b;  cin = flags_q[2]; end
      4'h6:       begin x = a; y = ~b; cin = flags_q[2]; end
      4'h7:       begin x = b; y = ~a; cin = flags_q[2]; end
      4'h0, 4'h8: begin isArith = 1'b0; logicRes = a & b;  end
      4'h1, 4'h9: begin isArith = 1'b0; logicRes = a ^ b;  end
      4'hC:       begin isArith = 1'b0; logicRes = a | b;  end
      4'hD:       begin isArith = 1'b0; logicRes = b;      end
      4'hE:       begin isArith = 1'b0; logicRes = a & ~b; end
      default:    begin isArith = 1'b0; logicRes = ~b;     end
    endcase
    sum       = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    aluRes    = isArith ? sum[MSB:0] : logicRes;
    aluN      = aluRes[MSB];
    aluZ      = (aluRes == '0);
    aluC      = isArith ? sum[WIDTH] : shift_carry;
    aluV      = isArith ? ((x[MSB] == y[MSB]) && (sum[MSB] != x[MSB])) : flags_q[3];
    isCompare = (opcode[3:2] == 2'b10);
    updFlags  = set_flags || isCompare;
  end

`ifdef ALU_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;

  localparam int STEPS = WIDTH / MUL_STEP;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, prod_q;
  logic [WIDTH-1:0] partial, prodNext;
  logic             mulSetFlags_q;
  logic             mulLast;

  assign mulReq  = mul_en;
  assign mulLast = (count_q == CW'(STEPS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && mul_en) state_d = MUL;
      default: if (mulLast)          state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
  end

  // One MUL_STEP-bit digit of the multiplier per cycle; the multiplicand is pre-shifted.
  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier_q[j]) partial = partial + (mcand_q << j);
    end
    prodNext = prod_q + partial;
  end
`else
  logic unused_mul;

  assign mulReq     = 1'b0;
  assign in_ready   = 1'b1;
  assign unused_mul = ^{mul_en, acc_en, acc};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q      <= '0;
      flags_q       <= '0;
      out_valid_q   <= 1'b0;
      write_rd_q    <= 1'b0;
`ifdef ALU_MUL_EN
      count_q       <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      prod_q        <= '0;
      mulSetFlags_q <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      if (accept && !mulReq) begin
        result_q    <= aluRes;
        write_rd_q  <= !isCompare;
        out_valid_q <= 1'b1;
        if (updFlags) flags_q <= {aluV, aluC, aluZ, aluN};
      end
`ifdef ALU_MUL_EN
      if (accept && mulReq) begin
        mcand_q       <= a;
        mplier_q      <= b;
        prod_q        <= acc_en ? acc : '0;
        mulSetFlags_q <= set_flags;
        count_q       <= '0;
      end
      if (state_q == MUL) begin
        prod_q   <= prodNext;
        mcand_q  <= mcand_q << MUL_STEP;
        mplier_q <= mplier_q >> MUL_STEP;
        count_q  <= count_q + 1'b1;
        if (mulLast) begin
          result_q    <= prodNext;
          out_valid_q <= 1'b1;
          write_rd_q  <= 1'b1;
          if (mulSetFlags_q) flags_q[1:0] <= {(prodNext == '0), prodNext[MSB]};
        end
      end
`endif
    end
  end

  assign result    = result_q;
  assign flags     = flags_q;
  assign out_valid = out_valid_q;
  assign write_rd  = write_rd_q;

endmodule
